// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: resolves the A/B operands for each decoded instruction and holds up to two
// in a skid queue in front of the ALU. Operand forwarding is built only when ALU_ISSUE_FWD_EN is defined.
module alu_issue_stage #(
  parameter int BITS    = 32,
  parameter int CBITS   = 5,
  parameter int REGBITS = 4
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               FLUSH,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [REGBITS-1:0] IN_RS1,
  input  logic [REGBITS-1:0] IN_RS2,
  input  logic [REGBITS-1:0] IN_RD,
  input  logic               IN_WREN,
  input  logic [BITS-1:0]    IN_A,
  input  logic [BITS-1:0]    IN_B,
  input  logic [BITS-1:0]    IN_IMM,
  input  logic               IN_USEIMM,
  input  logic [CBITS-1:0]   IN_CTL,
  input  logic               FWD_EX_V,
  input  logic [REGBITS-1:0] FWD_EX_RD,
  input  logic [BITS-1:0]    FWD_EX_DATA,
  input  logic               FWD_MEM_V,
  input  logic [REGBITS-1:0] FWD_MEM_RD,
  input  logic [BITS-1:0]    FWD_MEM_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [BITS-1:0]    ALU_A,
  output logic [BITS-1:0]    ALU_B,
  output logic [CBITS-1:0]   ALU_CTL,
  output logic [REGBITS-1:0] OUT_RD,
  output logic               OUT_WREN,
  output logic [1:0]         DBG_STATE
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // IN_READY is registered and depends only on the occupancy; OUT_VALID never waits on OUT_READY.

  localparam int EW = 2 * BITS + CBITS + REGBITS + 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic [EW-1:0]   head_q, head_d;
  logic [EW-1:0]   tail_q, tail_d;

  logic [BITS-1:0] opnd_a;
  logic [BITS-1:0] opnd_b;
  logic [EW-1:0]   new_entry;
  logic            accept;
  logic            issue;

`ifndef ALU_ISSUE_FWD_EN
  logic fwd_unused;
  assign fwd_unused = ^{FWD_EX_V, FWD_EX_RD, FWD_EX_DATA, FWD_MEM_V, FWD_MEM_RD, FWD_MEM_DATA};
`endif

  // Register 0 reads as zero regardless of any forward source claiming it.
  always_comb begin
    opnd_a = IN_A;
    opnd_b = IN_B;
`ifdef ALU_ISSUE_FWD_EN
    if (FWD_EX_V && (FWD_EX_RD == IN_RS1)) begin
      opnd_a = FWD_EX_DATA;
    end else if (FWD_MEM_V && (FWD_MEM_RD == IN_RS1)) begin
      opnd_a = FWD_MEM_DATA;
    end
    if (FWD_EX_V && (FWD_EX_RD == IN_RS2)) begin
      opnd_b = FWD_EX_DATA;
    end else if (FWD_MEM_V && (FWD_MEM_RD == IN_RS2)) begin
      opnd_b = FWD_MEM_DATA;
    end
`endif
    if (IN_RS1 == '0) begin
      opnd_a = '0;
    end
    if (IN_RS2 == '0) begin
      opnd_b = '0;
    end
    if (IN_USEIMM) begin
      opnd_b = IN_IMM;
    end
  end

  assign new_entry = {opnd_a, opnd_b, IN_CTL, IN_RD, IN_WREN};

  assign OUT_VALID = (state_q != S_EMPTY);
  assign IN_READY  = in_ready_q;
  assign accept    = IN_VALID & in_ready_q & ~FLUSH;
  assign issue     = OUT_VALID & OUT_READY;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (FLUSH) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            head_d  = new_entry;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && issue) begin
            head_d = new_entry;
          end else if (accept) begin
            tail_d  = new_entry;
            state_d = S_FULL;
          end else if (issue) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (issue) begin
            head_d  = tail_q;
            state_d = S_ONE;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
    in_ready_d = (state_d != S_FULL);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign ALU_A     = head_q[EW-1 -: BITS];
  assign ALU_B     = head_q[EW-1-BITS -: BITS];
  assign ALU_CTL   = head_q[REGBITS+CBITS -: CBITS];
  assign OUT_RD    = head_q[REGBITS:1];
  assign OUT_WREN  = head_q[0];
  assign DBG_STATE = state_q;

endmodule
